// File: rtl/freq_wave_gen.sv
// Square-wave synthesiser: prescaled phase accumulator driven by a clamped frequency code.
// Optional triangle output enabled by defining TRI_OUT_EN.
module freq_wave_gen #(
    parameter int ACC_W    = 12,
    parameter int PRESCALE = 4,
    parameter int FREQ_MAX = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] freq,
    input  logic       enable,
    output logic       wave_out,
    output logic       sync_pulse,
    output logic       active,
    output logic [7:0] freq_applied
`ifdef TRI_OUT_EN
    ,
    output logic [7:0] tri_out
`endif
);

    localparam int         PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [7:0] FREQ_CAP = 8'(FREQ_MAX);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [PRE_W-1:0]   pre_cnt_reg, pre_cnt_next;
    logic [7:0]         freq_q_reg, freq_q_next;
    logic [7:0]         inc_reg, inc_next;
    logic [7:0]         freq_applied_reg, freq_applied_next;
    logic               sync_reg, sync_next;
    logic [ACC_W:0]     sum;
    logic               tick;

    assign tick = (pre_cnt_reg == PRE_W'(PRESCALE - 1));
    assign sum  = {1'b0, acc_reg} + {{(ACC_W - 7){1'b0}}, inc_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            acc_reg          <= '0;
            pre_cnt_reg      <= '0;
            freq_q_reg       <= '0;
            inc_reg          <= '0;
            freq_applied_reg <= '0;
            sync_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            acc_reg          <= acc_next;
            pre_cnt_reg      <= pre_cnt_next;
            freq_q_reg       <= freq_q_next;
            inc_reg          <= inc_next;
            freq_applied_reg <= freq_applied_next;
            sync_reg         <= sync_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        acc_next          = acc_reg;
        pre_cnt_next      = pre_cnt_reg;
        inc_next          = inc_reg;
        freq_applied_next = freq_applied_reg;
        sync_next         = 1'b0;
        freq_q_next       = (freq > FREQ_CAP) ? FREQ_CAP : freq;

        case (state_reg)
            IDLE: begin
                acc_next     = '0;
                pre_cnt_next = '0;
                if (enable && freq_q_reg != 8'd0) begin
                    state_next        = RUN;
                    inc_next          = freq_q_reg;
                    freq_applied_next = freq_q_reg;
                end
            end
            RUN: begin
                if (tick) begin
                    pre_cnt_next = '0;
                    acc_next     = sum[ACC_W-1:0];
                    if (sum[ACC_W]) begin
                        sync_next = 1'b1;
                        // Stop wins over a pending increment change at the same wrap.
                        if (!enable || freq_q_reg == 8'd0) begin
                            state_next = IDLE;
                            acc_next   = '0;
                        end else if (freq_q_reg != inc_reg) begin
                            inc_next          = freq_q_reg;
                            freq_applied_next = freq_q_reg;
                        end
                    end
                end else begin
                    pre_cnt_next = pre_cnt_reg + PRE_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                acc_next   = '0;
            end
        endcase
    end

    assign wave_out     = acc_reg[ACC_W-1];
    assign sync_pulse   = sync_reg;
    assign active       = (state_reg == RUN);
    assign freq_applied = freq_applied_reg;

`ifdef TRI_OUT_EN
    logic [6:0] tri_t;
    assign tri_t = acc_reg[ACC_W-2 -: 7];

    // Fold the falling half so the ramp mirrors the rising half.
    always_comb begin
        tri_out = 8'd0;
        if (state_reg == RUN) begin
            if (acc_reg[ACC_W-1])
                tri_out = 8'hFF - {tri_t, 1'b0};
            else
                tri_out = {tri_t, 1'b0};
        end
    end
`endif

endmodule

// File: tb/tb_freq_wave_gen.sv
// Directed bench for freq_wave_gen with ACC_W=8, PRESCALE=1.
module tb_freq_wave_gen;

    logic       clk;
    logic       rst;
    logic [7:0] freq;
    logic       enable;
    logic       wave_out;
    logic       sync_pulse;
    logic       active;
    logic [7:0] freq_applied;
`ifdef TRI_OUT_EN
    logic [7:0] tri_out;
`endif

    int checks = 0;
    int errors = 0;

    freq_wave_gen #(.ACC_W(8), .PRESCALE(1), .FREQ_MAX(99)) dut (
        .clk          (clk),
        .rst          (rst),
        .freq         (freq),
        .enable       (enable),
        .wave_out     (wave_out),
        .sync_pulse   (sync_pulse),
        .active       (active),
        .freq_applied (freq_applied)
`ifdef TRI_OUT_EN
        ,
        .tri_out      (tri_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for k clocks after entering RUN with increment 32.
    task automatic chk_phase32(input string tag, input int k);
        logic [7:0] a;
        logic [7:0] tri_exp;
        a = 8'((32 * k) % 256);
        chk({tag, "_wave"}, {31'd0, wave_out}, {31'd0, a[7]});
        chk({tag, "_sync"}, {31'd0, sync_pulse}, {31'd0, (k > 0 && k % 8 == 0)});
        tri_exp = a[7] ? (8'hFF - {a[6:0], 1'b0}) : {a[6:0], 1'b0};
`ifdef TRI_OUT_EN
        chk({tag, "_tri"}, {24'd0, tri_out}, {24'd0, tri_exp});
`endif
        $display("step %s k=%0d acc=%0d wave=%0b sync=%0b tri_exp=%0d", tag, k, a, wave_out, sync_pulse, tri_exp);
    endtask

    initial begin
        rst    = 1'b1;
        freq   = 8'd0;
        enable = 1'b0;
        #2;
        chk("rst_wave", {31'd0, wave_out}, 32'd0);
        chk("rst_sync", {31'd0, sync_pulse}, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd0);
        chk("rst_fa", {24'd0, freq_applied}, 32'd0);
        step();
        step();
        rst = 1'b0;

        // enable with a zero code must never start
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("zero_active", {31'd0, active}, 32'd0);
            chk("zero_wave", {31'd0, wave_out}, 32'd0);
        end

        // Start at 32: RUN two edges after the code is applied
        freq = 8'd32;
        step();
        chk("start_active_e1", {31'd0, active}, 32'd0);
        step();
        chk("start_active_e2", {31'd0, active}, 32'd1);
        chk("start_fa", {24'd0, freq_applied}, 32'd32);
        for (int k = 0; k <= 21; k++) begin
            if (k > 0) step();
            chk_phase32("f32", k);
        end

        // Switch to 64 mid-high-phase; current period must complete at 32
        freq = 8'd64;
        step();
        chk_phase32("sw22", 22);
        chk("sw22_fa", {24'd0, freq_applied}, 32'd32);
        step();
        chk_phase32("sw23", 23);
        chk("sw23_fa", {24'd0, freq_applied}, 32'd32);
        for (int k = 0; k <= 8; k++) begin
            step();
            chk("f64_wave", {31'd0, wave_out}, {31'd0, (k % 4 >= 2)});
            chk("f64_sync", {31'd0, sync_pulse}, {31'd0, (k % 4 == 0)});
            chk("f64_fa", {24'd0, freq_applied}, 32'd64);
            $display("step f64 k=%0d wave=%0b sync=%0b fa=%0d", k, wave_out, sync_pulse, freq_applied);
        end

        // Out-of-range code clamps to 99; takes effect at next wrap (4 steps of 64 from acc=0)
        freq = 8'd150;
        step();
        step();
        step();
        chk("clamp_fa_before", {24'd0, freq_applied}, 32'd64);
        step();
        chk("clamp_fa", {24'd0, freq_applied}, 32'd99);
        chk("clamp_sync", {31'd0, sync_pulse}, 32'd1);
        step();
        chk("clamp_wave99", {31'd0, wave_out}, 32'd0);
        chk("clamp_sync99", {31'd0, sync_pulse}, 32'd0);
        step();
        chk("clamp_wave198", {31'd0, wave_out}, 32'd1);
        $display("step clamp fa=%0d wave=%0b", freq_applied, wave_out);

        // Asynchronous reset between clock edges, during high phase
        freq = 8'd32;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wave", {31'd0, wave_out}, 32'd0);
        chk("arst_active", {31'd0, active}, 32'd0);
        chk("arst_fa", {24'd0, freq_applied}, 32'd0);
        chk("arst_sync", {31'd0, sync_pulse}, 32'd0);
        $display("step async_reset wave=%0b active=%0b fa=%0d", wave_out, active, freq_applied);
        step();
        step();
        rst = 1'b0;
        step();
        chk("restart_active_e1", {31'd0, active}, 32'd0);
        step();
        chk("restart_active_e2", {31'd0, active}, 32'd1);
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) step();
            chk_phase32("rs", k);
        end

        // Drop enable mid-high-phase: finish the period, then stop with a final sync
        enable = 1'b0;
        step();
        chk("stop14_active", {31'd0, active}, 32'd1);
        chk("stop14_wave", {31'd0, wave_out}, 32'd1);
        step();
        chk("stop15_active", {31'd0, active}, 32'd1);
        chk("stop15_wave", {31'd0, wave_out}, 32'd1);
        step();
        chk("stop16_active", {31'd0, active}, 32'd0);
        chk("stop16_wave", {31'd0, wave_out}, 32'd0);
        chk("stop16_sync", {31'd0, sync_pulse}, 32'd1);
        $display("step stop active=%0b wave=%0b sync=%0b", active, wave_out, sync_pulse);
        step();
        chk("stop17_sync", {31'd0, sync_pulse}, 32'd0);
        chk("stop17_active", {31'd0, active}, 32'd0);
        chk("stop17_wave", {31'd0, wave_out}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_wave_gen.md
Name: freq_wave_gen

Overview:
- Downstream stage of the BCD-to-binary digitization block.
- Consumes the 8-bit binary frequency code `freq` (0..99) and synthesises a square wave using a prescaled phase accumulator.
- Frequency changes, starts and stops take effect only at a period boundary, so the output never produces runt pulses.
- Output feeds the signal-generator output path of the fuzzy controller.

Parameters:
- ACC_W, 12: phase accumulator width in bits; legal range 8..16.
- PRESCALE, 4: clocks per accumulator step; must be >= 1.
- FREQ_MAX, 99: clamp ceiling applied to the incoming frequency code.

Ports:
- clk  in  1: system clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- freq  in  8: binary frequency code from the digitization stage.
- enable  in  1: run request.
- wave_out  out  1: square-wave output; equals acc[ACC_W-1].
- sync_pulse  out  1: one-cycle strobe at each period wrap.
- active  out  1: high while in state RUN.
- freq_applied  out  8: increment currently in use.

Behaviour:
- Reset: asynchronous, active-high on rst, no clock needed. Clears state to IDLE; acc, pre_cnt, freq_q, inc, freq_applied to 0; wave_out, sync_pulse, active to 0. Reset mid-run aborts the current period immediately.
- Input register: freq_q <= min(freq, FREQ_MAX) every clock. Inputs take 1 cycle to reach freq_q.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 in RUN only; held at 0 in IDLE.
  - tick = (pre_cnt == PRESCALE-1). PRESCALE=1 gives tick every cycle.
- State IDLE:
  - acc=0, wave_out=0, active=0.
  - Go to RUN when enable=1 and freq_q!=0. On that edge: inc<=freq_q, freq_applied<=freq_q, acc stays 0.
  - enable=1 with freq_q=0 stays in IDLE.
- State RUN:
  - active=1. On tick: {carry, acc} <= acc + inc, so acc wraps modulo 2^ACC_W.
  - On a carry tick, sync_pulse=1 for the next cycle, coinciding with acc's wrapped value. No sync_pulse on entry to RUN.
  - On a carry tick, if enable=0 or freq_q=0: go to IDLE and force acc=0.
  - Otherwise, if freq_q != inc: load inc<=freq_q and freq_applied<=freq_q on that same edge.
  - freq changes between carries are ignored until the next carry. The last value present at the carry wins.
- Simultaneous events: stop has priority over increment update at a carry.
- Output timing:
  - wave_out is a registered bit: acc MSB, 0 in IDLE.
  - Average period = PRESCALE*2^ACC_W/inc clocks. Exact and 50% duty when inc is a power of two.

Optional Feature:
- Macro TRI_OUT_EN.
- When defined, adds port tri_out out 8. With t = acc[ACC_W-2:ACC_W-8]:
  - tri_out = {t,1'b0} when acc MSB=0.
  - tri_out = 8'hFF - {t,1'b0} when acc MSB=1.
  - tri_out = 0 in IDLE and on reset. Combinational from acc, so no extra latency.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- ACC_W=8, PRESCALE=1, freq=32, enable=1 after reset:
  - RUN 2 cycles after freq/enable applied.
  - wave_out 4 clocks low / 4 high, repeating.
  - sync_pulse every 8 clocks; freq_applied=32.
- Same setup, freq switched 32->64 mid-high-phase:
  - Current 8-clock period completes.
  - freq_applied=64 from the wrap edge, then 4-clock periods (2 low / 2 high).
- freq=150 (0x96) -> freq_applied=99; acc steps by 99 per clock.
- enable dropped mid-period at freq=32:
  - wave_out finishes its high phase.
  - At the wrap: active=0, wave_out=0, acc=0, and a final sync_pulse is seen.
  - freq=0 with enable=1 from reset: stays IDLE, wave_out=0 indefinitely.
- rst asserted mid-high-phase, asynchronously between clock edges: wave_out, active, freq_applied go to 0 without a clock edge; restart after release gives the normal first period.
- With TRI_OUT_EN, freq=32, PRESCALE=1, ACC_W=8: tri_out sequence 0,64,128,192,255,191,127,63, repeating.
